// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, NOP encoding, fetch FSM states and response
// record for the instruction fetch memory.
package ifetch_pkg;
   localparam int INST_W_DEF = 20;
   localparam int ADDR_W_DEF = 20;
   localparam logic [INST_W_DEF-1:0] NOP = '0;
   typedef enum logic {IDLE, READ} fetch_state_t;
   typedef struct packed {
      logic [INST_W_DEF-1:0] inst;
      logic [ADDR_W_DEF-1:0] addr;
      logic                  err;
   } resp_t;
endpackage

// File: rtl/inst_resp_fifo.sv
// inst_resp_fifo: 2-entry synchronous response FIFO with flush; push and pop
// together while full is legal and leaves the count unchanged.
module inst_resp_fifo #(
   parameter int W = 41
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] slot [2];
   logic wp, rp, do_push, do_pop;
   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = slot[rp];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= 1'b0;
         rp    <= 1'b0;
         count <= 2'd0;
      end else if (flush) begin
         wp    <= 1'b0;
         rp    <= 1'b0;
         count <= 2'd0;
      end else begin
         if (do_push) wp <= ~wp;
         if (do_pop) rp <= ~rp;
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push && !flush) slot[wp] <= din;
   end
endmodule

// File: rtl/inst_mem_fetch.sv
// inst_mem_fetch: synchronous instruction memory with valid/ready fetch, load port, flush and fault reporting
module inst_mem_fetch
   import ifetch_pkg::*;
#(
   parameter int    INST_W    = INST_W_DEF,
   parameter int    ADDR_W    = ADDR_W_DEF,
   parameter int    DEPTH     = 32,
   parameter int    WRAP_MODE = 1,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [INST_W-1:0] resp_inst,
   output logic              resp_err,
   output logic [ADDR_W-1:0] resp_addr,
   input  logic              flush,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [INST_W-1:0] ld_data
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int RW    = INST_W + ADDR_W + 1;
   logic [INST_W-1:0] mem [DEPTH];
   fetch_state_t state, state_nx;
   logic alive, accept, req_oor, ld_oor, rd_valid, rd_err;
   logic push, pop, fifo_full, fifo_empty;
   logic [INST_W-1:0] rd_inst;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        fifo_cnt;
   logic [RW-1:0]     fifo_dout;
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   end
   assign req_oor  = (WRAP_MODE == 0) && (req_addr >= ADDR_W'(DEPTH));
   assign ld_oor   = (WRAP_MODE == 0) && (ld_addr >= ADDR_W'(DEPTH));
   assign rd_valid = (state == READ);
   assign req_ready = alive & ~flush & ((fifo_cnt + {1'b0, rd_valid}) < 2'd2);
   assign accept    = req_valid & req_ready;
   always_ff @(posedge clk) begin
      if (ld_en && !ld_oor) mem[ld_addr[IDX_W-1:0]] <= ld_data;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive <= 1'b0;
         state <= IDLE;
      end else begin
         alive <= 1'b1;
         state <= state_nx;
      end
   end
   always_comb state_nx = (accept && !flush) ? READ : IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_inst <= '0;
         rd_addr <= '0;
         rd_err  <= 1'b0;
      end else if (accept) begin
         rd_inst <= req_oor ? INST_W'(NOP) : mem[req_addr[IDX_W-1:0]];
         rd_addr <= req_addr;
         rd_err  <= req_oor;
      end
   end
   assign push = rd_valid & ~(fifo_empty & resp_ready) & ~fifo_full;
   assign pop  = resp_ready & ~fifo_empty;
   inst_resp_fifo #(.W(RW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   ({rd_inst, rd_addr, rd_err}),
      .dout  (fifo_dout),
      .count (fifo_cnt),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
   assign resp_valid = rd_valid | ~fifo_empty;
   assign {resp_inst, resp_addr, resp_err} = fifo_empty ? {rd_inst, rd_addr, rd_err} : fifo_dout;
endmodule

// File: tb/tb_inst_mem_fetch.sv
// tb_inst_mem_fetch: randomized self-checking bench; a wrapping and a faulting
// instance share stimulus and are checked against a queue-based memory model.
module tb_inst_mem_fetch;
   typedef struct packed {
      logic [19:0] inst;
      logic [19:0] addr;
      logic        err;
   } rsp_t;
   logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, resp_ready = 1'b0, flush = 1'b0, ld_en = 1'b0;
   logic [19:0] req_addr = '0, ld_addr = '0, ld_data = '0;
   logic req_ready, resp_valid, resp_err, w0_req_ready, w0_resp_valid, w0_resp_err;
   logic [19:0] resp_inst, resp_addr, w0_resp_inst, w0_resp_addr;
   int checks = 0, passed = 0;
   logic [19:0] ref_mem [32];
   rsp_t exp1[$], exp0[$], got1[$], want1[$], got0[$], want0[$];
   bit acc;

   always #5 clk = ~clk;

   inst_mem_fetch #(.WRAP_MODE(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
      .resp_addr(resp_addr), .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );
   inst_mem_fetch #(.WRAP_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(w0_req_ready), .req_addr(req_addr),
      .resp_valid(w0_resp_valid), .resp_ready(resp_ready), .resp_inst(w0_resp_inst), .resp_err(w0_resp_err),
      .resp_addr(w0_resp_addr), .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   // one clock cycle: sample handshakes before the edge, advance the model after it
   task automatic tick();
      bit a1, a0, p1, p0;
      rsp_t r1, r0, x;
      x = 'x;
      #1;
      a1 = req_valid & req_ready;
      a0 = req_valid & w0_req_ready;
      p1 = resp_valid & resp_ready;
      p0 = w0_resp_valid & resp_ready;
      r1 = {resp_inst, resp_addr, resp_err};
      r0 = {w0_resp_inst, w0_resp_addr, w0_resp_err};
      @(posedge clk);
      if (flush) begin
         exp1.delete();
         exp0.delete();
      end else begin
         if (p1) begin
            got1.push_back(r1);
            if (exp1.size() != 0) want1.push_back(exp1.pop_front()); else want1.push_back(x);
         end
         if (p0) begin
            got0.push_back(r0);
            if (exp0.size() != 0) want0.push_back(exp0.pop_front()); else want0.push_back(x);
         end
         if (a1) exp1.push_back({ref_mem[req_addr[4:0]], req_addr, 1'b0});
         if (a0) exp0.push_back(req_addr >= 20'd32 ? {20'h0, req_addr, 1'b1} : {ref_mem[req_addr[4:0]], req_addr, 1'b0});
      end
      acc = a1;
      if (ld_en) ref_mem[ld_addr[4:0]] = ld_data;
      @(negedge clk);
   endtask

   task automatic clr();
      got1.delete(); want1.delete(); got0.delete(); want0.delete();
   endtask

   task automatic drain(output bit ok);
      req_valid = 1'b0;
      resp_ready = 1'b1;
      for (int i = 0; i < 12 && (exp1.size() != 0 || exp0.size() != 0); i++) tick();
      ok = (exp1.size() == 0 && exp0.size() == 0);
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", req_ready); else passed++;
      checks++; if (resp_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", resp_valid); else passed++;
      checks++; if ({resp_inst, resp_addr, resp_err} !== 41'h0) $display("FAIL reset_resp got=%h/%h/%b want=0", resp_inst, resp_addr, resp_err); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (req_ready !== 1'b1) $display("FAIL post_reset_ready got=%b want=1", req_ready); else passed++;
      for (int i = 0; i < 32; i++) begin
         ld_en = 1'b1;
         ld_addr = 20'(i);
         ld_data = (i == 16) ? 20'h08180 : (i < 8) ? 20'(i) : 20'($urandom);
         tick();
      end
      ld_en = 1'b0;
   endtask

   task automatic test_stream();
      bit ok;
      clr();
      resp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         req_valid = (i < 8);
         req_addr = 20'(i);
         #1;
         if (i < 8) begin
            checks++; if (req_ready !== 1'b1) $display("FAIL stream_ready cyc%0d got=%b want=1", i, req_ready); else passed++;
         end
         if (i >= 1 && i <= 8) begin
            checks++; if (resp_valid !== 1'b1) $display("FAIL stream_valid cyc%0d got=%b want=1", i, resp_valid); else passed++;
            checks++; if (resp_inst !== 20'(i - 1)) $display("FAIL stream_inst cyc%0d got=%h want=%h", i, resp_inst, 20'(i - 1)); else passed++;
         end
         tick();
      end
      drain(ok);
      checks++; if (!ok || got1.size() != 8) $display("FAIL stream_count got=%0d want=8", got1.size()); else passed++;
      for (int i = 0; i < got1.size(); i++) begin
         checks++; if (got1[i] !== want1[i]) $display("FAIL stream_rsp%0d got=%h want=%h", i, got1[i], want1[i]); else passed++;
      end
   endtask

   task automatic test_backpressure();
      bit ok, took;
      logic [19:0] a [3];
      int n;
      clr();
      for (int i = 0; i < 3; i++) a[i] = 20'($urandom_range(0, 31));
      resp_ready = 1'b0;
      req_valid = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         req_addr = a[n];
         #1;
         checks++; if (req_ready !== (i < 2)) $display("FAIL bp_ready cyc%0d got=%b want=%b", i, req_ready, i < 2); else passed++;
         if (i == 3) begin
            checks++; if (resp_addr !== a[0] || resp_valid !== 1'b1) $display("FAIL bp_hold got=%h/%b want=%h/1", resp_addr, resp_valid, a[0]); else passed++;
         end
         tick();
         if (acc && n < 2) n++;
      end
      resp_ready = 1'b1;
      took = 1'b0;
      for (int j = 0; j < 4 && !took; j++) begin
         tick();
         took = acc;
      end
      checks++; if (!took) $display("FAIL bp_third_accept got=0 want=1"); else passed++;
      drain(ok);
      checks++; if (!ok || got1.size() != 3) $display("FAIL bp_count got=%0d want=3", got1.size()); else passed++;
      for (int i = 0; i < got1.size(); i++) begin
         checks++; if (got1[i] !== want1[i]) $display("FAIL bp_rsp%0d got=%h want=%h", i, got1[i], want1[i]); else passed++;
      end
   endtask

   task automatic test_range();
      bit ok;
      clr();
      resp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr = 20'd40;
      tick();
      req_addr = 20'd48;
      tick();
      drain(ok);
      checks++; if (!ok || got0.size() != 2 || got1.size() != 2) $display("FAIL range_count got=%0d/%0d want=2/2", got1.size(), got0.size()); else passed++;
      checks++; if (got0[0].err !== 1'b1 || got0[0].inst !== 20'h0) $display("FAIL range_err40 got=%h/%b want=00000/1", got0[0].inst, got0[0].err); else passed++;
      checks++; if (got0[1].err !== 1'b1) $display("FAIL range_err48 got=%b want=1", got0[1].err); else passed++;
      checks++; if (got1[1].inst !== 20'h08180 || got1[1].err !== 1'b0) $display("FAIL range_wrap48 got=%h/%b want=08180/0", got1[1].inst, got1[1].err); else passed++;
      checks++; if (got1[0].inst !== ref_mem[8]) $display("FAIL range_wrap40 got=%h want=%h", got1[0].inst, ref_mem[8]); else passed++;
   endtask

   task automatic test_rbw();
      bit ok;
      logic [19:0] old5;
      clr();
      old5 = ref_mem[5];
      resp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr = 20'd5;
      ld_en = 1'b1;
      ld_addr = 20'd5;
      ld_data = 20'hABCDE;
      tick();
      ld_en = 1'b0;
      tick();
      drain(ok);
      checks++; if (!ok || got1.size() != 2) $display("FAIL rbw_count got=%0d want=2", got1.size()); else passed++;
      checks++; if (got1[0].inst !== old5) $display("FAIL rbw_old got=%h want=%h", got1[0].inst, old5); else passed++;
      checks++; if (got1[1].inst !== 20'hABCDE) $display("FAIL rbw_new got=%h want=abcde", got1[1].inst); else passed++;
   endtask

   task automatic test_flush();
      bit ok;
      clr();
      resp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr = 20'd1;
      tick();
      req_addr = 20'd2;
      tick();
      req_valid = 1'b0;
      tick();
      checks++; if (resp_valid !== 1'b1 || resp_addr !== 20'd1) $display("FAIL flush_pre got=%b/%h want=1/00001", resp_valid, resp_addr); else passed++;
      flush = 1'b1;
      req_valid = 1'b1;
      req_addr = 20'd3;
      #1;
      checks++; if (req_ready !== 1'b0 || w0_req_ready !== 1'b0) $display("FAIL flush_ready got=%b/%b want=0/0", req_ready, w0_req_ready); else passed++;
      tick();
      flush = 1'b0;
      req_valid = 1'b0;
      checks++; if (resp_valid !== 1'b0 || w0_resp_valid !== 1'b0) $display("FAIL flush_valid got=%b/%b want=0/0", resp_valid, w0_resp_valid); else passed++;
      tick();
      checks++; if (resp_valid !== 1'b0) $display("FAIL flush_noaccept got=%b want=0", resp_valid); else passed++;
      resp_ready = 1'b1;
      req_valid = 1'b1;
      tick();
      drain(ok);
      checks++; if (!ok || got1.size() != 1 || got1[0].addr !== 20'd3 || got1[0].inst !== 20'd3) $display("FAIL flush_recover got=%0d/%h want=1/00003", got1.size(), got1[0].inst); else passed++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      clr();
      resp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr = 20'd5;
      tick();
      req_addr = 20'd6;
      tick();
      req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || w0_resp_valid !== 1'b0) $display("FAIL rstmid_valid got=%b/%b want=0/0", resp_valid, w0_resp_valid); else passed++;
      checks++; if ({resp_inst, resp_addr, resp_err} !== 41'h0) $display("FAIL rstmid_resp got=%h/%h/%b want=0", resp_inst, resp_addr, resp_err); else passed++;
      checks++; if (req_ready !== 1'b0) $display("FAIL rstmid_ready got=%b want=0", req_ready); else passed++;
      exp1.delete();
      exp0.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (req_ready !== 1'b1) $display("FAIL rstmid_ready_after got=%b want=1", req_ready); else passed++;
      clr();
      resp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr = 20'd5;
      tick();
      drain(ok);
      checks++; if (!ok || got1.size() != 1 || got1[0].inst !== 20'hABCDE) $display("FAIL rstmid_mem got=%0d/%h want=1/abcde", got1.size(), got1[0].inst); else passed++;
   endtask

   task automatic test_random();
      bit ok, stall;
      rsp_t prev;
      clr();
      stall = 1'b0;
      prev = '0;
      for (int c = 0; c < 400; c++) begin
         req_valid = ($urandom % 4) != 0;
         req_addr = 20'($urandom_range(0, 63));
         resp_ready = ($urandom % 3) != 0;
         ld_en = ($urandom % 4) == 0;
         ld_addr = 20'($urandom_range(0, 31));
         ld_data = 20'($urandom);
         flush = ($urandom % 40) == 0;
         #1;
         checks++; if (req_ready !== (!flush && exp1.size() < 2)) $display("FAIL rnd_ready cyc%0d got=%b want=%b", c, req_ready, !flush && exp1.size() < 2); else passed++;
         if (stall) begin
            checks++; if (resp_valid !== 1'b1 || {resp_inst, resp_addr, resp_err} !== prev) $display("FAIL rnd_stable cyc%0d got=%b/%h want=1/%h", c, resp_valid, {resp_inst, resp_addr, resp_err}, prev); else passed++;
         end
         stall = resp_valid & ~resp_ready & ~flush;
         prev = {resp_inst, resp_addr, resp_err};
         tick();
      end
      flush = 1'b0;
      ld_en = 1'b0;
      drain(ok);
      checks++; if (!ok) $display("FAIL rnd_drain got=%0d/%0d want=0/0", exp1.size(), exp0.size()); else passed++;
      for (int i = 0; i < got1.size(); i++) begin
         checks++; if (got1[i] !== want1[i]) $display("FAIL rnd_wrap_rsp%0d got=%h want=%h", i, got1[i], want1[i]); else passed++;
      end
      for (int i = 0; i < got0.size(); i++) begin
         checks++; if (got0[i] !== want0[i]) $display("FAIL rnd_fault_rsp%0d got=%h want=%h", i, got0[i], want0[i]); else passed++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_range();
      test_rbw();
      test_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
